// File: rtl/audio_recorder_pkg.sv
// Shared types and defaults for the audio recorder slice.
// RECORDER_PAUSE_EN adds the PAUSE state to the recorder FSM.
package audio_recorder_pkg;
  localparam int DEF_ADDR_W = 23;
  localparam int DEF_DATA_W = 16;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REC,
`ifdef RECORDER_PAUSE_EN
    ST_PAUSE,
`endif
    ST_FLUSH,
    ST_DONE,
    ST_HOLD
  } rec_state_e;
endpackage

// File: rtl/recorder_fifo.sv
// Small synchronous sample FIFO; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module recorder_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);
  localparam int PW    = $clog2(DEPTH);
  localparam int CNT_W = PW + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign o_empty = (count == '0);
  assign o_full  = (count == CNT_W'(DEPTH));
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);
  assign o_head  = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/audio_recorder.sv
// Records ADC samples into SRAM between a start and an inclusive end address.
// Optional RECORDER_PAUSE_EN enables the PAUSE state driven by record_pause.
module audio_recorder
  import audio_recorder_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   record_start,
  input  logic [1:0][ADDR_W-1:0] record_select,
  input  logic                   record_pause,
  input  logic                   record_stop,
  output logic                   record_done,
  input  logic                   i_smp_valid,
  input  logic [DATA_W-1:0]      i_smp_data,
  output logic                   o_sram_wr_req,
  output logic [ADDR_W-1:0]      o_sram_addr,
  output logic [DATA_W-1:0]      o_sram_wdata,
  input  logic                   i_sram_wr_ack,
  output logic [ADDR_W-1:0]      o_rec_len,
  output logic                   o_overflow,
  output rec_state_e             o_state
);
  // SRAM handshake: o_sram_wr_req is the valid, i_sram_wr_ack the ready. Once
  // raised, req/addr/wdata stay put until the cycle ack is seen; that cycle is
  // the transfer, after which req drops for at least one cycle.
  rec_state_e        state;
  logic [ADDR_W-1:0] end_addr;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_clr;
  logic              active;
  logic              push;
  logic              pop;
  logic              last_ack;

`ifndef RECORDER_PAUSE_EN
  logic unused_pause;
  assign unused_pause = record_pause;
`endif

  always_comb begin
    active = (state == ST_REC) || (state == ST_FLUSH);
`ifdef RECORDER_PAUSE_EN
    if (state == ST_PAUSE) active = 1'b1;
`endif
  end

  // Outside a take the FIFO is held empty, which also discards leftovers.
  assign fifo_clr = i_rst || !active;
  assign push     = (state == ST_REC) && i_smp_valid && !record_stop;
  assign pop      = o_sram_wr_req && i_sram_wr_ack;
  assign last_ack = pop && (o_sram_addr == end_addr);
  assign o_state  = state;

  recorder_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_clr   (fifo_clr),
    .i_push  (push),
    .i_pop   (pop),
    .i_data  (i_smp_data),
    .o_head  (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= ST_IDLE;
      end_addr      <= '0;
      record_done   <= 1'b0;
      o_sram_wr_req <= 1'b0;
      o_sram_addr   <= '0;
      o_sram_wdata  <= '0;
      o_rec_len     <= '0;
      o_overflow    <= 1'b0;
    end else begin
      record_done <= 1'b0;
      if (push && fifo_full && !pop) o_overflow <= 1'b1;

      if (active) begin
        if (pop) begin
          o_sram_wr_req <= 1'b0;
          o_rec_len     <= o_rec_len + 1'b1;
          if (!last_ack) o_sram_addr <= o_sram_addr + 1'b1;
        end else if (!o_sram_wr_req && !fifo_empty) begin
          o_sram_wr_req <= 1'b1;
          o_sram_wdata  <= fifo_head;
        end
      end

      case (state)
        ST_IDLE: begin
          if (record_start) begin
            end_addr    <= record_select[1];
            o_sram_addr <= record_select[0];
            o_rec_len   <= '0;
            o_overflow  <= 1'b0;
            if (record_select[1] < record_select[0]) begin
              state       <= ST_DONE;
              record_done <= 1'b1;
            end else begin
              state <= ST_REC;
            end
          end
        end
        ST_REC: begin
          if (last_ack) begin
            state       <= ST_DONE;
            record_done <= 1'b1;
          end else if (record_stop) begin
            state <= ST_FLUSH;
          end
`ifdef RECORDER_PAUSE_EN
          else if (record_pause) begin
            state <= ST_PAUSE;
          end
`endif
        end
`ifdef RECORDER_PAUSE_EN
        ST_PAUSE: begin
          if (last_ack) begin
            state       <= ST_DONE;
            record_done <= 1'b1;
          end else if (record_stop) begin
            state <= ST_FLUSH;
          end else if (!record_pause) begin
            state <= ST_REC;
          end
        end
`endif
        ST_FLUSH: begin
          if (last_ack || (fifo_empty && !o_sram_wr_req)) begin
            state       <= ST_DONE;
            record_done <= 1'b1;
          end
        end
        ST_DONE: state <= ST_HOLD;
        ST_HOLD: if (!record_start) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_audio_recorder.sv
// Randomized scoreboard bench for audio_recorder; honours RECORDER_PAUSE_EN.
module tb_audio_recorder;
  import audio_recorder_pkg::*;

  localparam int AW = 23;
  localparam int DW = 16;

  typedef enum int {P_IDLE, P_REC, P_PAUSE, P_FLUSH, P_END} phase_e;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic record_start = 1'b0, record_pause = 1'b0, record_stop = 1'b0;
  logic [AW-1:0] sel_start = '0, sel_end = '0;
  logic record_done, i_smp_valid = 1'b0;
  logic [DW-1:0] i_smp_data = '0;
  logic o_sram_wr_req, i_sram_wr_ack, o_overflow;
  logic [AW-1:0] o_sram_addr, o_rec_len;
  logic [DW-1:0] o_sram_wdata;
  rec_state_e dbg_state;

  int vectors = 0, miscompares = 0;
  int done_cnt = 0, req_cnt = 0, done_base = 0, req_base = 0;
  bit ack_hold = 1'b0;
  int ack_max = 0, ack_dly = 0, ack_wait = 0;

  logic [AW+DW-1:0] exp_q[$];
  phase_e phase = P_IDLE;
  logic [AW-1:0] m_start;
  int n_acc = 0, n_wr = 0, cap = 0, exp_len = 0;
  bit m_ovf = 1'b0;

  audio_recorder #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .record_start(record_start),
    .record_select({sel_end, sel_start}), .record_pause(record_pause),
    .record_stop(record_stop), .record_done(record_done),
    .i_smp_valid(i_smp_valid), .i_smp_data(i_smp_data),
    .o_sram_wr_req(o_sram_wr_req), .o_sram_addr(o_sram_addr),
    .o_sram_wdata(o_sram_wdata), .i_sram_wr_ack(i_sram_wr_ack),
    .o_rec_len(o_rec_len), .o_overflow(o_overflow), .o_state(dbg_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // SRAM slave: ack a random 0..ack_max cycles after the request is seen.
  initial begin
    i_sram_wr_ack = 1'b0;
    forever begin
      @(posedge i_clk); #1;
      if (i_sram_wr_ack) i_sram_wr_ack = 1'b0;
      else if (o_sram_wr_req && !ack_hold) begin
        if (ack_wait >= ack_dly) begin
          i_sram_wr_ack = 1'b1;
          ack_wait = 0;
          ack_dly = $urandom_range(0, ack_max);
        end else ack_wait++;
      end
    end
  end

  // Reference model: take bookkeeping from the recorder rules, pushing the
  // expected {address, data} of every sample that will reach SRAM.
  initial begin
    bit pop;
    forever begin
      @(negedge i_clk);
      pop = o_sram_wr_req && i_sram_wr_ack;
      if (i_rst) begin
        phase = P_IDLE; exp_q.delete(); n_acc = 0; n_wr = 0;
      end else begin
        case (phase)
          P_IDLE: if (record_start) begin
            m_start = sel_start; n_acc = 0; n_wr = 0; m_ovf = 1'b0; exp_len = 0;
            if (sel_end < sel_start) phase = P_END;
            else begin cap = int'(sel_end - sel_start) + 1; phase = P_REC; end
          end
          P_END: if (!record_start) phase = P_IDLE;
          default: begin
            if (phase == P_REC && i_smp_valid && !record_stop) begin
              if (n_acc - n_wr < FIFO_DEPTH || pop) begin
                if (n_acc < cap) exp_q.push_back({m_start + AW'(n_acc), i_smp_data});
                n_acc++;
              end else m_ovf = 1'b1;
            end
            if (pop) n_wr++;
            if (n_wr == cap || (phase == P_FLUSH && n_acc == n_wr)) begin
              phase = P_END;
              exp_len = (n_acc < cap) ? n_acc : cap;
            end else if (record_stop) phase = P_FLUSH;
`ifdef RECORDER_PAUSE_EN
            else if (phase == P_REC && record_pause) phase = P_PAUSE;
            else if (phase == P_PAUSE && !record_pause) phase = P_REC;
`endif
          end
        endcase
      end
    end
  end

  // Monitor: check each accepted write and that pending requests stay stable.
  initial begin
    logic [AW+DW-1:0] e;
    logic prev_req = 1'b0, prev_ack = 1'b0, prev_rst = 1'b1;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_data = '0;
    forever begin
      @(negedge i_clk);
      if (!i_rst && o_sram_wr_req && i_sram_wr_ack) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                   o_sram_addr, o_sram_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("sram_write", {o_sram_addr, o_sram_wdata}, e);
        end
      end
      if (prev_req && !prev_ack && !prev_rst)
        chk("req_hold", {o_sram_wr_req, o_sram_addr, o_sram_wdata}, {1'b1, prev_addr, prev_data});
      if (record_done) done_cnt++;
      if (o_sram_wr_req) req_cnt++;
      prev_req = o_sram_wr_req; prev_ack = i_sram_wr_ack; prev_rst = i_rst;
      prev_addr = o_sram_addr; prev_data = o_sram_wdata;
    end
  end

  task automatic start_take(input logic [AW-1:0] s, input logic [AW-1:0] e, input bit hold);
    @(posedge i_clk); #1;
    sel_start = s; sel_end = e; record_start = 1'b1;
    done_base = done_cnt; req_base = req_cnt;
    @(posedge i_clk); #1;
    if (!hold) record_start = 1'b0;
  endtask

  task automatic send_sample(input logic [DW-1:0] d, input bit stop);
    @(posedge i_clk); #1;
    i_smp_valid = 1'b1; i_smp_data = d; record_stop = stop;
    @(posedge i_clk); #1;
    i_smp_valid = 1'b0; record_stop = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic finish_take(input string nm);
    int n = 0;
    while (done_cnt == done_base && n < 400) begin @(negedge i_clk); n++; end
    if (done_cnt == done_base) begin
      vectors++; miscompares++;
      $display("FAIL %s_timeout: no record_done within 400 cycles", nm);
    end
    repeat (3) @(negedge i_clk);
    chk({nm, "_done_pulses"}, done_cnt - done_base, 1);
    chk({nm, "_rec_len"}, o_rec_len, exp_len);
    chk({nm, "_overflow"}, o_overflow, m_ovf);
    chk({nm, "_leftover"}, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, nsmp;
    logic [AW-1:0] s;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    chk("reset_outputs", {record_done, o_sram_wr_req, o_sram_addr, o_sram_wdata, o_rec_len, o_overflow}, '0);
    chk("reset_state", dbg_state, ST_IDLE);

    // held-high start must not retrigger until it drops
    ack_max = 0;
    start_take(23'h300, 23'h301, 1'b1);
    send_sample(16'h1234, 1'b0);
    send_sample(16'h5678, 1'b0);
    finish_take("held_take");
    req_base = req_cnt;
    repeat (20) @(negedge i_clk);
    chk("held_no_retrigger_done", done_cnt - done_base, 1);
    chk("held_no_retrigger_req", req_cnt - req_base, 0);
    #1 record_start = 1'b0;
    idle_cycles(3);

    // basic four-word take filling the window exactly
    start_take(23'h10, 23'h13, 1'b0);
    for (int i = 1; i <= 4; i++) send_sample(16'hA000 + 16'(i), 1'b0);
    finish_take("fill4");
    chk("fill4_len_const", o_rec_len, 4);

    // stop after three samples; sample in the stop cycle is discarded
    start_take(23'h20, 23'h2F, 1'b0);
    for (int i = 0; i < 3; i++) send_sample(16'(16'hB000 + i), 1'b0);
    send_sample(16'hBEEF, 1'b1);
    finish_take("stop3");
    chk("stop3_len_const", o_rec_len, 3);

    // ack withheld while six samples arrive
    ack_hold = 1'b1;
    start_take(23'h40, 23'h7F, 1'b0);
    for (int i = 0; i < 6; i++) send_sample(16'(16'hC000 + i), 1'b0);
    idle_cycles(4);
    ack_hold = 1'b0;
    idle_cycles(12);
    send_sample(16'hCFFF, 1'b1);
    finish_take("overflow");
    chk("overflow_const", {o_overflow, o_rec_len}, {1'b1, 23'd4});

    // end below start
    start_take(23'h08, 23'h05, 1'b0);
    @(negedge i_clk);
    chk("empty_done_now", record_done, 1'b1);
    @(negedge i_clk);
    chk("empty_done_once", record_done, 1'b0);
    finish_take("empty");
    chk("empty_no_req", req_cnt - req_base, 0);

`ifdef RECORDER_PAUSE_EN
    start_take(23'h80, 23'hFF, 1'b0);
    send_sample(16'hD001, 1'b0);
    send_sample(16'hD002, 1'b0);
    record_pause = 1'b1;
    idle_cycles(2);
    for (int i = 0; i < 5; i++) send_sample(16'(16'hE000 + i), 1'b0);
    record_pause = 1'b0;
    idle_cycles(2);
    send_sample(16'hD003, 1'b0);
    send_sample(16'hD004, 1'b0);
    send_sample(16'hD005, 1'b1);
    finish_take("pause");
    chk("pause_len_const", o_rec_len, 4);
`endif

    // randomized takes
    for (int t = 0; t < 12; t++) begin
      s = AW'($urandom_range(0, 'h200));
      len = $urandom_range(1, 10);
      nsmp = $urandom_range(0, 14);
      ack_max = $urandom_range(0, 4);
      start_take(s, s + AW'(len - 1), 1'b0);
      for (int i = 0; i < nsmp; i++) begin
        idle_cycles($urandom_range(0, 3));
        record_pause = ($urandom_range(0, 3) == 0);
        send_sample(16'($urandom_range(0, 16'hFFFF)), 1'b0);
      end
      record_pause = 1'b0;
      idle_cycles($urandom_range(0, 4));
      send_sample(16'($urandom_range(0, 16'hFFFF)), 1'b1);
      finish_take("random");
    end

    // reset in the middle of a pending write
    ack_hold = 1'b1;
    start_take(23'h100, 23'h1FF, 1'b0);
    send_sample(16'hF00D, 1'b0);
    begin
      int n = 0;
      while (!o_sram_wr_req && n < 10) begin @(posedge i_clk); #1; n++; end
    end
    chk("rst_req_seen", o_sram_wr_req, 1'b1);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_mid_outputs", {record_done, o_sram_wr_req, o_sram_addr, o_sram_wdata, o_rec_len, o_overflow}, '0);
    chk("rst_mid_state", dbg_state, ST_IDLE);
    ack_hold = 1'b0;
    idle_cycles(3);

    // recovery take after reset
    ack_max = 1;
    start_take(23'h10, 23'h12, 1'b0);
    for (int i = 0; i < 3; i++) send_sample(16'($urandom_range(0, 16'hFFFF)), 1'b0);
    finish_take("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/audio_recorder.md
AUDIO_RECORDER -- requirements
Module: audio_recorder

Interface
REQ-001 Parameter ADDR_W, 23, SRAM word address width.
REQ-002 Parameter DATA_W, 16, audio sample and SRAM word width.
REQ-003 Ports: one clock; reset is synchronous and active-high.
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous active-high reset.
REQ-004 Control and sample ports:
- record_start  in  1  level; request to record while high.
- record_select  in  2x ADDR_W  [0] start address, [1] end address, inclusive.
- record_pause  in  1  level; suspend sample capture.
- record_stop  in  1  pulse or level; terminate recording.
- record_done  out  1  one-cycle completion pulse.
- i_smp_valid  in  1  one-cycle strobe for a new ADC sample.
- i_smp_data  in  DATA_W  sample value, valid with the strobe.
REQ-005 SRAM and status ports:
- o_sram_wr_req  out  1  write request.
- o_sram_addr  out  ADDR_W  write address.
- o_sram_wdata  out  DATA_W  write data.
- i_sram_wr_ack  in  1  write accepted this cycle.
- o_rec_len  out  ADDR_W  words written in the last or current take.
- o_overflow  out  1  sticky; a sample was dropped because the FIFO was full.

Function
REQ-006 The block SHALL implement the FSM IDLE, REC, PAUSE, FLUSH, DONE, HOLD.
REQ-007 IDLE: record_start=1 SHALL latch start/end addresses, clear o_rec_len and o_overflow, and enter REC next cycle; if end<start it SHALL go to DONE with o_rec_len=0.
REQ-008 REC: each i_smp_valid SHALL push i_smp_data into a 4-entry FIFO; a push into a full FIFO is dropped and sets o_overflow, except when a pop happens in the same cycle, in which case the push is accepted.
REQ-009 The write port SHALL present the FIFO head with o_sram_wr_req=1 and hold o_sram_addr and o_sram_wdata stable until i_sram_wr_ack; on ack it SHALL pop, increment the address and o_rec_len, and may re-request on the next cycle.
REQ-010 Ack of the write to the end address SHALL enter DONE; the address SHALL NOT wrap, and remaining FIFO contents and later samples SHALL be discarded.
REQ-011 REC with record_pause=1 SHALL enter PAUSE; PAUSE ignores samples, keeps draining the FIFO, and returns to REC when record_pause=0.
REQ-012 record_stop=1 in REC or PAUSE SHALL enter FLUSH, taking priority over pause and over a sample in the same cycle (that sample is discarded).
REQ-013 FLUSH SHALL accept no samples, drain the FIFO to SRAM (still bounded by the end address), and enter DONE when empty with no request pending.
REQ-014 DONE SHALL assert record_done for exactly one cycle, then enter HOLD.
REQ-015 HOLD SHALL wait until record_start=0, then enter IDLE, so a held-high record_start never retriggers.
REQ-016 o_sram_wr_req SHALL be registered and SHALL be 0 in IDLE, DONE and HOLD.
REQ-017 o_rec_len and o_overflow SHALL hold their values through HOLD and IDLE until the next start.

Reset
REQ-018 Reset SHALL force IDLE, flush the FIFO, and zero every output (record_done, o_sram_wr_req, o_sram_addr, o_sram_wdata, o_rec_len, o_overflow) on the next edge, including mid-write; a pending un-acked write SHALL be abandoned.

Configuration
REQ-019 With RECORDER_PAUSE_EN defined, REQ-011 applies.
REQ-020 Without RECORDER_PAUSE_EN, the PAUSE state does not exist, record_pause is ignored, and every other behaviour is unchanged.

Structure
REQ-021 A shared package SHALL hold the recorder state enum, the FIFO depth constant (4), and the ADDR_W and DATA_W defaults.
REQ-022 The FIFO SHALL be a sub-module named recorder_fifo (synchronous, full/empty flags, simultaneous push/pop supported).

Verification
REQ-023 The bench SHALL cover these scenarios:
- Start 0x000010, end 0x000013, 4 samples 0xA001..0xA004, ack after 1 cycle each -> writes to 0x10..0x13 in order, one record_done pulse, o_rec_len=4.
- Start 0x20, end 0x2F, 3 samples then record_stop -> 3 writes, FLUSH, record_done, o_rec_len=3; a sample in the stop cycle is not written.
- Ack withheld 10 cycles while 6 samples arrive -> first 4 buffered, o_overflow=1, only 4 words written.
- End 0x05 < start 0x08 -> record_done 1 cycle after start, no o_sram_wr_req, o_rec_len=0.
- record_start held high 20 cycles after record_done -> no second take; it restarts only after record_start drops and rises again.
- i_rst asserted while o_sram_wr_req=1 -> next cycle all outputs are 0, state IDLE; with RECORDER_PAUSE_EN, pause for 5 samples -> those samples are not written.
